// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: issues in-order imem requests with credit-based
// flow control, buffers returned words in a small FIFO and hands
// {pc, pc+4, instr} to decode over a valid/ready handshake.
// Ports: clk_i/rst_i (sync, active-high); imem_* request/response channel;
// redirect_i/redirect_pc_i from execute; instr_valid_o/instr_ready_i,
// instr_o, pc_o, pc_plus4_o to decode.
// Option IFU_MISALIGN_EN: adds misalign_o; a misaligned redirect target
// halts fetch until the next aligned redirect.
module instr_fetch_unit #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'hBFC0_0000,
  parameter int unsigned           DEPTH      = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_ready_i,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] pc_plus4_o
`ifdef IFU_MISALIGN_EN
  ,
  output logic                  misalign_o
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);
  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h13);
  localparam logic [DATA_WIDTH-1:0] FOUR = DATA_WIDTH'(4);

  typedef enum logic {
    BOOT,
    FETCH
  } state_e;

  state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] fetch_pc, rsp_pc;
  logic [CW-1:0]         outstanding, discard, count;
  logic [AW-1:0]         rd_ptr, wr_ptr;
  logic [DATA_WIDTH-1:0] pc_mem    [DEPTH];
  logic [DATA_WIDTH-1:0] instr_mem [DEPTH];

  logic                  req, accept, push, pop, drop;
  logic                  credit_ok, halt, bad_tgt;
  logic [DATA_WIDTH-1:0] tgt;

  // Low target bits are never used as an address.
  assign tgt = {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};

`ifdef IFU_MISALIGN_EN
  logic misalign_q;

  assign bad_tgt    = |redirect_pc_i[1:0];
  assign halt       = misalign_q;
  assign misalign_o = misalign_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      misalign_q <= 1'b0;
    end else if (redirect_i) begin
      misalign_q <= bad_tgt;
    end
  end
`else
  logic unused_tgt_lsb;

  assign unused_tgt_lsb = ^redirect_pc_i[1:0];
  assign bad_tgt        = 1'b0;
  assign halt           = 1'b0;
`endif

  // Credits cover in-flight plus buffered words, so every response
  // is guaranteed a free slot.
  assign credit_ok = ({1'b0, outstanding} + {1'b0, count}) < LIMIT;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    unique case (state_q)
      BOOT: begin
        state_d = FETCH;
      end
      FETCH: begin
        req = !redirect_i && !halt && credit_ok;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  assign imem_req_o  = req;
  assign imem_addr_o = fetch_pc;

  assign accept = req && imem_ready_i;
  assign drop   = imem_rvalid_i && (discard != '0);
  assign push   = imem_rvalid_i && (discard == '0) && !redirect_i;
  assign pop    = instr_valid_o && instr_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(imem_rvalid_i);
      if (redirect_i) begin
        // Everything still in flight becomes stale, including a
        // response landing in this very cycle.
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        count   <= '0;
        discard <= outstanding - CW'(imem_rvalid_i);
        if (!bad_tgt) begin
          fetch_pc <= tgt;
          rsp_pc   <= tgt;
        end
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
          rsp_pc <= rsp_pc + FOUR;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        count <= count + CW'(push) - CW'(pop);
        if (drop) begin
          discard <= discard - CW'(1);
        end
        if (accept) begin
          fetch_pc <= fetch_pc + FOUR;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem[wr_ptr]    <= rsp_pc;
      instr_mem[wr_ptr] <= imem_rdata_i;
    end
  end

  assign instr_valid_o = count != '0;
  assign instr_o    = instr_valid_o ? instr_mem[rd_ptr] : NOP;
  assign pc_o       = instr_valid_o ? pc_mem[rd_ptr] : '0;
  assign pc_plus4_o = instr_valid_o ? pc_mem[rd_ptr] + FOUR : '0;

  rsp_legal: assert property (
    @(posedge clk_i) disable iff (rst_i)
    imem_rvalid_i |-> (outstanding != '0)
  );

  credit_bound: assert property (
    @(posedge clk_i) disable iff (rst_i)
    outstanding <= CW'(DEPTH)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit with an epoch-based reference
// model of the program stream and an in-order memory model.
module tb_instr_fetch_unit;

  localparam int DEPTH = 2;
  localparam logic [31:0] RST_PC = 32'hBFC0_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
`ifdef IFU_MISALIGN_EN
  logic        misalign_o;
`endif

  instr_fetch_unit #(
    .DATA_WIDTH(32),
    .RESET_PC  (RST_PC),
    .DEPTH     (DEPTH)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ready_i (imem_ready_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i),
    .instr_o      (instr_o),
    .pc_o         (pc_o),
    .pc_plus4_o   (pc_plus4_o)
`ifdef IFU_MISALIGN_EN
    ,
    .misalign_o   (misalign_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  req_t        inflight[$];
  logic [31:0] mbuf[$];
  logic [31:0] next_addr;
  int          epoch;
  int          cyc;
  int          since;
  int          last_due;
  int          lat_min;
  int          lat_max;
  bit          misal;
  int          total;
  int          bad;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hA5A5_1234 ^ {a[15:0], a[31:16]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic do_reset();
    rst_i         = 1'b1;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    imem_ready_i  = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    instr_ready_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_req", imem_req_o, 0);
    chk("rst_valid", instr_valid_o, 0);
    chk("rst_instr", instr_o, NOP);
    chk("rst_pc", pc_o, 0);
    chk("rst_pc4", pc_plus4_o, 0);
`ifdef IFU_MISALIGN_EN
    chk("rst_misalign", misalign_o, 0);
`endif
    inflight.delete();
    mbuf.delete();
    next_addr = RST_PC;
    epoch     = 0;
    misal     = 1'b0;
    since     = 0;
    last_due  = 0;
    cyc++;
    rst_i = 1'b0;
  endtask

  // One clock cycle; entered and left at a falling edge.
  task automatic step(input bit rdr, input logic [31:0] tgt,
                      input bit dready, input bit mready);
    bit   rsp;
    bit   exp_req;
    int   due;
    req_t e;
    if (mbuf.size() == 0) begin
      chk("valid", instr_valid_o, 0);
      chk("nop", instr_o, NOP);
      chk("pc_empty", pc_o, 0);
      chk("pc4_empty", pc_plus4_o, 0);
    end else begin
      chk("valid", instr_valid_o, 1);
      chk("pc", pc_o, mbuf[0]);
      chk("instr", instr_o, memf(mbuf[0]));
      chk("pc4", pc_plus4_o, mbuf[0] + 32'd4);
    end
`ifdef IFU_MISALIGN_EN
    chk("misalign", misalign_o, {31'd0, misal});
`endif
    redirect_i    = rdr;
    redirect_pc_i = tgt;
    instr_ready_i = dready;
    imem_ready_i  = mready;
    rsp = (inflight.size() != 0) && (inflight[0].due <= cyc);
    imem_rvalid_i = rsp;
    imem_rdata_i  = rsp ? memf(inflight[0].addr) : $urandom;
    #1;
    exp_req = (since >= 1) && !rdr && !misal &&
              (inflight.size() + mbuf.size() < DEPTH);
    chk("req", imem_req_o, {31'd0, exp_req});
    if (exp_req) chk("addr", imem_addr_o, next_addr);
    if (mbuf.size() != 0 && dready) void'(mbuf.pop_front());
    if (rsp) begin
      e = inflight.pop_front();
      if (!rdr && e.epoch == epoch) mbuf.push_back(e.addr);
    end
    if (imem_req_o && mready) begin
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due < last_due) due = last_due;
      last_due = due;
      e.addr  = imem_addr_o;
      e.epoch = epoch;
      e.due   = due;
      inflight.push_back(e);
      next_addr = next_addr + 32'd4;
    end
    if (rdr) begin
      mbuf.delete();
      epoch++;
`ifdef IFU_MISALIGN_EN
      if (tgt[1:0] != 2'b00) begin
        misal = 1'b1;
      end else begin
        misal     = 1'b0;
        next_addr = tgt;
      end
`else
      next_addr = tgt & 32'hFFFF_FFFC;
`endif
    end
    since++;
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b1);
  endtask

  task automatic run_random(input int n);
    logic [31:0] t;
    int          k;
    for (int i = 0; i < n; i++) begin
      k = $urandom_range(0, 3);
      t = $urandom & 32'hFFFF_FFFC;
      if (k == 1) t = 32'hFFFF_FFF8;
      if (k == 2) t = t | 32'd2;
      step(($urandom_range(0, 19) == 0), t,
           ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1);
    end
  endtask

  initial begin
    bit found;
    total   = 0;
    bad     = 0;
    cyc     = 0;
    lat_min = 1;
    lat_max = 1;
    do_reset();

    // straight-line fetch, ready memory, 1-cycle latency
    run(20);

    // decode stall for 5 cycles
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, 1'b1);
    run(10);

    // redirect with two requests outstanding, latency 3
    lat_min = 3;
    lat_max = 3;
    found   = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (inflight.size() == 2) begin
        step(1'b1, 32'h0000_0100, 1'b1, 1'b1);
        found = 1'b1;
      end else begin
        step(1'b0, '0, 1'b1, 1'b1);
      end
    end
    chk("two_outstanding_hit", {31'd0, found}, 1);
    run(15);

    // redirect coinciding with a response and a pop
    lat_min = 1;
    lat_max = 1;
    found   = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mbuf.size() != 0 && inflight.size() != 0 &&
          inflight[0].due <= cyc) begin
        step(1'b1, 32'h0000_4000, 1'b1, 1'b1);
        found = 1'b1;
      end else begin
        step(1'b0, '0, 1'b1, 1'b1);
      end
    end
    chk("same_cycle_hit", {31'd0, found}, 1);
    run(5);

    // misaligned target, then aligned recovery
    step(1'b1, 32'h0000_0102, 1'b1, 1'b1);
    run(4);
    step(1'b1, 32'h0000_0200, 1'b1, 1'b1);
    run(10);

    // memory ready toggling, random stalls and redirects
    lat_min = 1;
    lat_max = 3;
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1, $urandom_range(0, 1) == 1);
    run_random(400);

    // reset mid-operation, then wrap-around region
    do_reset();
    run(4);
    step(1'b1, 32'hFFFF_FFF0, 1'b1, 1'b1);
    run(12);
    run_random(300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
